cpu_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 32-bit core. It fetches and accesses data through separate req/ack memory ports, so it tolerates memories with arbitrary latency. It sequences each instruction through an explicit state machine and reports halt, illegal-instruction and retire status to the enclosing system. The data width, PC width and reset vector are parameters.

---
 rtl/cpu_mc_pkg.sv | 51 +++++
 rtl/cpu_mc_regfile.sv | 44 ++++
 rtl/cpu_mc.sv | 198 +++++++++++++++++++
 tb/tb_cpu_mc.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// ----------------------------------------------------------------
// cpu_mc_pkg : opcodes, FSM states and instruction field positions
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package cpu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_JZ   = 4'd4;
  localparam logic [3:0] OP_JNZ  = 4'd5;
  localparam logic [3:0] OP_JAL  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    OPC_ADD  = OP_ADD,
    OPC_ADDI = OP_ADDI,
    OPC_LD   = OP_LD,
    OPC_ST   = OP_ST,
    OPC_JZ   = OP_JZ,
    OPC_JNZ  = OP_JNZ,
    OPC_JAL  = OP_JAL,
    OPC_HALT = OP_HALT
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 24;
  localparam int RS2_MSB = 23;
  localparam int RS2_LSB = 22;
  localparam int IMM_MSB = 21;
  localparam int IMM_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/cpu_mc_regfile.sv
// ----------------------------------------------------------------
// cpu_mc_regfile : 4 x XLEN registers, 2 async reads, 1 sync write
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module cpu_mc_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [1:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [1:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_q [4];
  logic [XLEN-1:0] regs_d [4];

  // r0 is forced to zero so it can never be read back as anything else
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ----------------------------------------------------------------
// cpu_mc : multi-cycle 4-register core with req/ack memory ports
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          AW       = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, ld_q, ld_d;
  logic            illegal_q, illegal_d;

  opcode_e           opc;
  logic [1:0]        rd, rs1, rs2;
  logic signed [21:0] imm_raw;
  logic [XLEN-1:0]   rs1_data, rs2_data, sum;
  logic [AW-1:0]     target, pc_plus4;
  logic              misaligned, take;
  logic              rf_we;
  logic [XLEN-1:0]   rf_wdata;
  logic              in_mem;

  assign opc     = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
  assign rd      = ir_q[RD_MSB:RD_LSB];
  assign rs1     = ir_q[RS1_MSB:RS1_LSB];
  assign rs2     = ir_q[RS2_MSB:RS2_LSB];
  assign imm_raw = ir_q[IMM_MSB:IMM_LSB];

  assign sum        = a_q + ((opc == OPC_ADD) ? b_q : imm_q);
  assign target     = AW'(sum);
  assign pc_plus4   = pc_q + AW'(4);
  assign misaligned = (target[1:0] != 2'b00);
  assign take       = (opc == OPC_JZ) ? (b_q == '0) : (b_q != '0);

  cpu_mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .raddr_a (rs1),
    .rdata_a (rs1_data),
    .raddr_b (rs2),
    .rdata_b (rs2_data)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    ld_d      = ld_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wdata  = sum;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: if (imem_ack) begin
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rs1_data;
        b_d     = rs2_data;
        imm_d   = XLEN'(imm_raw);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opc)
          OPC_ADD, OPC_ADDI: begin
            rf_we   = 1'b1;
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_JZ, OPC_JNZ: begin
            if (take && misaligned) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              pc_d    = take ? target : pc_plus4;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
          OPC_JAL: begin
            if (misaligned) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              rf_we    = 1'b1;
              rf_wdata = XLEN'(pc_plus4);
              pc_d     = target;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
          end
          OPC_LD, OPC_ST: begin
            if (misaligned) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              state_d = S_MEM;
            end
          end
          OPC_HALT: state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      // Operands stay frozen in a_q/b_q/imm_q, which keeps address and data stable until ack
      S_MEM: if (dmem_ack) begin
        if (opc == OPC_ST) begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          ld_d    = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = ld_q;
        pc_d     = pc_plus4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      ld_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      ld_q      <= ld_d;
      illegal_q <= illegal_d;
    end
  end

  // Fetch request is masked while reset is held so all requests read low during reset
  assign in_mem     = (state_q == S_MEM);
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = in_mem;
  assign dmem_we    = in_mem && (opc == OPC_ST);
  assign dmem_addr  = in_mem ? target : '0;
  assign dmem_wdata = in_mem ? b_q : '0;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc.sv
// ----------------------------------------------------------------
// tb_cpu_mc : directed self-checking bench for cpu_mc
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_cpu_mc;
  import cpu_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- 32-bit core, RESET_PC = 0 ----------------
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        retire, halted, illegal;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;

  cpu_mc #(.XLEN(32), .AW(10), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          dwait = 0;
  int          dcnt = 0;
  logic        late_ack = 1'b0;

  assign imem_rdata = imem[imem_addr[9:2]];
  assign imem_ack   = imem_req;
  assign dmem_rdata = dmem[dmem_addr[9:2]];
  assign dmem_ack   = (dmem_req && (dcnt >= dwait)) || late_ack;

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
  end

  // ---------------- 16-bit core, RESET_PC = 0x3FC ----------------
  logic        rst16_n = 1'b0;
  logic        i16_req, i16_ack, d16_req, d16_we, d16_ack;
  logic        retire16, halted16, illegal16;
  logic [9:0]  i16_addr, d16_addr;
  logic [31:0] i16_rdata;
  logic [15:0] d16_wdata, d16_rdata;
  logic [31:0] imem16 [256];

  cpu_mc #(.XLEN(16), .AW(10), .RESET_PC(32'h3FC)) dut16 (
    .clk(clk), .rst_n(rst16_n),
    .imem_req(i16_req), .imem_addr(i16_addr), .imem_rdata(i16_rdata), .imem_ack(i16_ack),
    .dmem_req(d16_req), .dmem_we(d16_we), .dmem_addr(d16_addr), .dmem_wdata(d16_wdata),
    .dmem_rdata(d16_rdata), .dmem_ack(d16_ack),
    .retire(retire16), .halted(halted16), .illegal(illegal16)
  );

  assign i16_rdata = imem16[i16_addr[9:2]];
  assign i16_ack   = i16_req;
  assign d16_rdata = 16'h0;
  assign d16_ack   = d16_req;

  // ---------------- helpers ----------------
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic [21:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 28'h0};
    dwait = 0;
  endtask

  task automatic start();
    rst_n = 1'b0;
    late_ack = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int         ret_cyc[$];
  logic [9:0] fetch_pc[$];
  int         dreq_run, dreq_max, ncyc;
  logic       addr_moved, dreq_seen;

  // Cycle 1 is the first cycle after reset release; samples taken on the falling edge
  task automatic run(input int budget);
    logic [9:0] a0;
    a0 = '0;
    ret_cyc.delete();
    fetch_pc.delete();
    dreq_run = 0; dreq_max = 0; addr_moved = 1'b0; dreq_seen = 1'b0; ncyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (retire) ret_cyc.push_back(c);
      if (imem_req) fetch_pc.push_back(imem_addr);
      if (dmem_req) begin
        dreq_seen = 1'b1;
        if (dreq_run == 0) a0 = dmem_addr;
        else if (dmem_addr !== a0) addr_moved = 1'b1;
        dreq_run++;
        if (dreq_run > dreq_max) dreq_max = dreq_run;
      end else begin
        dreq_run = 0;
      end
      if (halted) begin
        ncyc = c;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, dmem_req, dmem_we, retire, halted, illegal} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 000000", {imem_req, dmem_req, dmem_we, retire, halted, illegal});
    end
    checks++;
    if (imem_addr !== 10'h000) begin
      failures++; $display("FAIL reset_imem_addr got %h want 000", imem_addr);
    end
    checks++;
    if ({dmem_addr, dmem_wdata} !== 42'h0) begin
      failures++; $display("FAIL reset_dmem_bus got %h/%h want 0/0", dmem_addr, dmem_wdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
      failures++; $display("FAIL reset_first_fetch got req=%b addr=%h want 1/000", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu();
    int exp_r[3] = '{3, 6, 9};
    clear_imem();
    imem[0] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'd5);
    imem[1] = enc(OP_ADDI, 2'd2, 2'd1, 2'd0, 22'h3FFFFE);
    imem[2] = enc(OP_ADD,  2'd3, 2'd1, 2'd2, 22'd0);
    start();
    run(60);
    checks++;
    if (ret_cyc.size() != 3) begin
      failures++; $display("FAIL alu_retire_count got %0d want 3", ret_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ret_cyc.size() || ret_cyc[i] != exp_r[i]) begin
        failures++;
        $display("FAIL alu_retire_cycle[%0d] got %0d want %0d", i, (i < ret_cyc.size()) ? ret_cyc[i] : -1, exp_r[i]);
      end
    end
    checks++;
    if (dut.u_regfile.regs_q[3] !== 32'd8) begin
      failures++; $display("FAIL alu_r3 got %h want 00000008", dut.u_regfile.regs_q[3]);
    end
    checks++;
    if (dut.u_regfile.regs_q[2] !== 32'd3) begin
      failures++; $display("FAIL alu_r2 got %h want 00000003", dut.u_regfile.regs_q[2]);
    end
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b0 || ncyc != 13) begin
      failures++; $display("FAIL alu_halt got halted=%b illegal=%b cyc=%0d want 1/0/13", halted, illegal, ncyc);
    end
    checks++;
    if (dut.pc_q !== 10'h00C) begin
      failures++; $display("FAIL alu_halt_pc got %h want 00c", dut.pc_q);
    end
  endtask

  task automatic test_mem();
    clear_imem();
    imem[0] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'h123);
    imem[1] = enc(OP_ST,   2'd0, 2'd0, 2'd1, 22'h40);
    imem[2] = enc(OP_LD,   2'd2, 2'd0, 2'd0, 22'h40);
    dwait = 3;
    start();
    run(80);
    checks++;
    if (ret_cyc.size() != 3 || ret_cyc[0] != 3 || ret_cyc[1] != 10 || ret_cyc[2] != 18) begin
      failures++; $display("FAIL mem_retire_cycles got %p want 3,10,18", ret_cyc);
    end
    checks++;
    if (ret_cyc.size() == 3 && (ret_cyc[2] - ret_cyc[1]) != 8) begin
      failures++; $display("FAIL mem_ld_latency got %0d want 8", ret_cyc[2] - ret_cyc[1]);
    end
    checks++;
    if (dreq_max != 4 || addr_moved !== 1'b0) begin
      failures++; $display("FAIL mem_req_hold got len=%0d moved=%b want 4/0", dreq_max, addr_moved);
    end
    checks++;
    if (dmem[16] !== 32'h123) begin
      failures++; $display("FAIL mem_store_data got %h want 00000123", dmem[16]);
    end
    checks++;
    if (dut.u_regfile.regs_q[2] !== 32'h123) begin
      failures++; $display("FAIL mem_load_r2 got %h want 00000123", dut.u_regfile.regs_q[2]);
    end
  endtask

  task automatic test_jump();
    logic [9:0] exp_pc[4] = '{10'h000, 10'h020, 10'h024, 10'h040};
    clear_imem();
    imem[0] = enc(OP_JZ,  2'd0, 2'd0, 2'd0, 22'h20);
    imem[8] = enc(OP_JNZ, 2'd0, 2'd0, 2'd0, 22'h0);
    imem[9] = enc(OP_JAL, 2'd1, 2'd0, 2'd0, 22'h40);
    start();
    run(60);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= fetch_pc.size() || fetch_pc[i] !== exp_pc[i]) begin
        failures++;
        $display("FAIL jump_fetch_pc[%0d] got %h want %h", i, (i < fetch_pc.size()) ? fetch_pc[i] : 10'h3FF, exp_pc[i]);
      end
    end
    checks++;
    if (dut.u_regfile.regs_q[1] !== 32'h28) begin
      failures++; $display("FAIL jump_jal_link got %h want 00000028", dut.u_regfile.regs_q[1]);
    end
    checks++;
    if (ret_cyc.size() != 3 || illegal !== 1'b0) begin
      failures++; $display("FAIL jump_retires got %0d illegal=%b want 3/0", ret_cyc.size(), illegal);
    end
  endtask

  task automatic test_illegal();
    clear_imem();
    imem[0] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'd7);
    imem[1] = 32'h9000_0000;
    start();
    run(40);
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || ncyc != 7) begin
      failures++; $display("FAIL illop_flags got ill=%b halt=%b cyc=%0d want 1/1/7", illegal, halted, ncyc);
    end
    checks++;
    if (ret_cyc.size() != 1 || dut.pc_q !== 10'h004 || dut.u_regfile.regs_q[1] !== 32'd7) begin
      failures++; $display("FAIL illop_state got ret=%0d pc=%h r1=%h want 1/004/7", ret_cyc.size(), dut.pc_q, dut.u_regfile.regs_q[1]);
    end
    clear_imem();
    imem[0] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'd7);
    imem[1] = enc(OP_LD,   2'd2, 2'd0, 2'd0, 22'h41);
    start();
    run(40);
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1) begin
      failures++; $display("FAIL misalign_flags got ill=%b halt=%b want 1/1", illegal, halted);
    end
    checks++;
    if (dreq_seen !== 1'b0 || dut.u_regfile.regs_q[2] !== 32'd0 || dut.pc_q !== 10'h004) begin
      failures++; $display("FAIL misalign_side_effect got req=%b r2=%h pc=%h want 0/0/004", dreq_seen, dut.u_regfile.regs_q[2], dut.pc_q);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'd5);
    imem[1] = enc(OP_ST,   2'd0, 2'd0, 2'd1, 22'h40);
    dwait = 100;
    start();
    for (int c = 1; c <= 8; c++) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++; $display("FAIL midmem_setup got dmem_req=%b want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 10'h000) begin
      failures++; $display("FAIL midmem_abort got d=%b i=%b pc=%h want 0/0/000", dmem_req, imem_req, imem_addr);
    end
    checks++;
    if (dut.u_regfile.regs_q[1] !== 32'd0) begin
      failures++; $display("FAIL midmem_regs_cleared got %h want 0", dut.u_regfile.regs_q[1]);
    end
    dwait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    late_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 late_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_DECODE || dut.pc_q !== 10'h000 || dut.ir_q !== imem[0]) begin
      failures++; $display("FAIL midmem_late_ack got state=%0d pc=%h ir=%h want 1/000/%h", dut.state_q, dut.pc_q, dut.ir_q, imem[0]);
    end
    run(40);
    checks++;
    if (ret_cyc.size() != 2 || dmem[16] !== 32'd5 || halted !== 1'b1) begin
      failures++; $display("FAIL midmem_rerun got ret=%0d mem=%h halt=%b want 2/5/1", ret_cyc.size(), dmem[16], halted);
    end
  endtask

  task automatic test_wrap16();
    logic [9:0] pcs[$];
    for (int i = 0; i < 256; i++) imem16[i] = {OP_HALT, 28'h0};
    imem16[255] = enc(OP_ADDI, 2'd1, 2'd0, 2'd0, 22'h7FFF);
    imem16[0]   = enc(OP_ADDI, 2'd1, 2'd1, 2'd0, 22'd1);
    rst16_n = 1'b0;
    @(posedge clk);
    #1 rst16_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (i16_req) pcs.push_back(i16_addr);
      if (halted16) break;
    end
    checks++;
    if (pcs.size() != 3 || pcs[0] !== 10'h3FC || pcs[1] !== 10'h000 || pcs[2] !== 10'h004) begin
      failures++; $display("FAIL wrap_pc_seq got %p want 3fc,000,004", pcs);
    end
    checks++;
    if (dut16.u_regfile.regs_q[1] !== 16'h8000) begin
      failures++; $display("FAIL xlen16_add got %h want 8000", dut16.u_regfile.regs_q[1]);
    end
    checks++;
    if (halted16 !== 1'b1 || illegal16 !== 1'b0) begin
      failures++; $display("FAIL xlen16_halt got halt=%b ill=%b want 1/0", halted16, illegal16);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_jump();
    test_illegal();
    test_reset_mid_mem();
    test_wrap16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
